// File: rtl/board_pkg.sv
// Board-level constants shared by the input-conditioning logic and its users.
package board_pkg;

  localparam int CLK_HZ        = 12_000_000;
  localparam int DEBOUNCE_20MS = CLK_HZ / 50;

  // Channel indices into the key_* vectors.
  localparam int KEY_START   = 0;
  localparam int KEY_RECOUNT = 1;
  localparam int KEY_SET0    = 2;
  localparam int KEY_SET1    = 3;
  localparam int KEY_SET2    = 4;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, polarity fix, stability counter,
// debounced level, press/release pulses and a press-toggled hold flag.
module key_debounce_ch
  import board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  input  logic toggle_clr,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_toggle
);

  // Counter only ever reaches DEBOUNCE_CYCLES-1, so clog2 bits always suffice.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Raw pin level meaning "not pressed"; synchroniser resets to it.
  localparam logic IDLE_LEVEL = (ACTIVE_LOW != 0);

  logic             sync1_reg, sync2_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;
  logic             toggle_reg, toggle_next;
  logic             sample;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= IDLE_LEVEL;
      sync2_reg <= IDLE_LEVEL;
    end else begin
      sync1_reg <= key_in;
      sync2_reg <= sync1_reg;
    end
  end

  // Debounce decision: count consecutive disagreeing cycles, commit at the top value.
  always_comb begin
    cnt_next     = cnt_reg;
    level_next   = level_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    toggle_next  = toggle_reg;

    sample = (ACTIVE_LOW != 0) ? ~sync2_reg : sync2_reg;

    if (sample == level_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_TOP) begin
      cnt_next     = '0;
      level_next   = sample;
      press_next   = sample;
      release_next = ~sample;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end

    // Clear wins over a coincident press; release leaves the flag alone.
    if (toggle_clr) begin
      toggle_next = 1'b0;
    end else if (press_next) begin
      toggle_next = ~toggle_reg;
    end
  end

  // Debounce state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      toggle_reg  <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      toggle_reg  <= toggle_next;
    end
  end

  assign key_level   = level_reg;
  assign key_press   = press_reg;
  assign key_release = release_reg;
  assign key_toggle  = toggle_reg;

endmodule

// File: rtl/key_conditioner.sv
// Conditions the raw board buttons/switches into clean clk-domain signals,
// one independent debounce channel per key.
module key_conditioner
  import board_pkg::*;
#(
  parameter int NUM_KEYS        = 5,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic [NUM_KEYS-1:0] toggle_clr,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_toggle
);

  // Channels share nothing but the clock and reset.
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .key_in     (key_in[gi]),
      .toggle_clr (toggle_clr[gi]),
      .key_level  (key_level[gi]),
      .key_press  (key_press[gi]),
      .key_release(key_release[gi]),
      .key_toggle (key_toggle[gi])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with an 8-cycle debounce, active-low keys.
module tb_key_conditioner;

  logic       clk;
  logic       rst;
  logic [4:0] key_in;
  logic [4:0] toggle_clr;
  logic [4:0] key_level;
  logic [4:0] key_press;
  logic [4:0] key_release;
  logic [4:0] key_toggle;

  int errors = 0;
  int checks = 0;

  key_conditioner #(
    .NUM_KEYS       (5),
    .DEBOUNCE_CYCLES(8),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .toggle_clr (toggle_clr),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_toggle (key_toggle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    key_in     = 5'h1F;
    toggle_clr = 5'h00;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    $display("step reset");
    chk("rst_level", key_level, 5'h00);
    chk("rst_press", key_press, 5'h00);
    chk("rst_release", key_release, 5'h00);
    chk("rst_toggle", key_toggle, 5'h00);

    // Clean press on key 0: level/press appear on the 10th edge after the change
    $display("step clean press key0");
    key_in[0] = 1'b0;
    repeat (9) tick();
    chk("press0_early_level", key_level, 5'h00);
    chk("press0_early_press", key_press, 5'h00);
    tick();
    chk("press0_level", key_level, 5'h01);
    chk("press0_press", key_press, 5'h01);
    chk("press0_toggle", key_toggle, 5'h01);
    tick();
    chk("press0_pulse_end", key_press, 5'h00);
    chk("press0_level_hold", key_level, 5'h01);
    chk("press0_toggle_hold", key_toggle, 5'h01);
    tick();

    // Release key 0
    $display("step release key0");
    key_in[0] = 1'b1;
    repeat (9) tick();
    chk("rel0_early_release", key_release, 5'h00);
    chk("rel0_early_level", key_level, 5'h01);
    tick();
    chk("rel0_release", key_release, 5'h01);
    chk("rel0_level", key_level, 5'h00);
    chk("rel0_press", key_press, 5'h00);
    chk("rel0_toggle", key_toggle, 5'h01);
    tick();
    chk("rel0_pulse_end", key_release, 5'h00);
    tick();

    // Second press on key 0 toggles back to 0
    $display("step second press key0");
    key_in[0] = 1'b0;
    repeat (10) tick();
    chk("press0b_press", key_press, 5'h01);
    chk("press0b_toggle", key_toggle, 5'h00);
    repeat (2) tick();
    key_in[0] = 1'b1;
    repeat (12) tick();
    chk("rel0b_level", key_level, 5'h00);
    chk("rel0b_toggle", key_toggle, 5'h00);

    // Bounce on key 1: low 3, high 2, low 5, then high -- never qualifies
    $display("step bounce key1");
    for (int i = 0; i < 25; i++) begin
      key_in[1] = (i < 3) ? 1'b0 : (i < 5) ? 1'b1 : (i < 10) ? 1'b0 : 1'b1;
      tick();
      chk("bounce_level", key_level, 5'h00);
      chk("bounce_press", key_press, 5'h00);
    end
    chk("bounce_toggle", key_toggle, 5'h00);

    // Clear priority, case 1: toggle=1, clear coincides with press
    $display("step clear with toggle=1");
    key_in[0] = 1'b0;
    repeat (10) tick();
    chk("clr1_setup_toggle", key_toggle, 5'h01);
    repeat (2) tick();
    key_in[0] = 1'b1;
    repeat (12) tick();
    key_in[0] = 1'b0;
    repeat (9) tick();
    toggle_clr[0] = 1'b1;
    tick();
    toggle_clr[0] = 1'b0;
    chk("clr1_press", key_press, 5'h01);
    chk("clr1_toggle", key_toggle, 5'h00);
    tick();
    chk("clr1_toggle_after", key_toggle, 5'h00);
    tick();
    key_in[0] = 1'b1;
    repeat (12) tick();

    // Clear priority, case 2: toggle=0, clear must suppress the flip
    $display("step clear with toggle=0");
    key_in[0] = 1'b0;
    repeat (9) tick();
    toggle_clr[0] = 1'b1;
    tick();
    toggle_clr[0] = 1'b0;
    chk("clr2_press", key_press, 5'h01);
    chk("clr2_toggle", key_toggle, 5'h00);
    tick();
    chk("clr2_toggle_after", key_toggle, 5'h00);
    tick();
    key_in[0] = 1'b1;
    repeat (12) tick();
    chk("clr2_toggle_release", key_toggle, 5'h00);

    // Parallel channels 0 and 4
    $display("step parallel keys 0 and 4");
    key_in = 5'h0E;
    repeat (9) tick();
    chk("par_early_press", key_press, 5'h00);
    tick();
    chk("par_press", key_press, 5'h11);
    chk("par_level", key_level, 5'h11);
    chk("par_toggle", key_toggle, 5'h11);
    tick();
    chk("par_pulse_end", key_press, 5'h00);

    // Reset mid-debounce on key 2 (count 5); keys 0 and 4 still held
    $display("step reset mid-debounce key2");
    key_in[2] = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_level", key_level, 5'h00);
    chk("mid_rst_press", key_press, 5'h00);
    chk("mid_rst_release", key_release, 5'h00);
    chk("mid_rst_toggle", key_toggle, 5'h00);
    repeat (9) tick();
    chk("requal_early_press", key_press, 5'h00);
    chk("requal_early_level", key_level, 5'h00);
    tick();
    chk("requal_press", key_press, 5'h15);
    chk("requal_level", key_level, 5'h15);
    chk("requal_toggle", key_toggle, 5'h15);
    tick();
    chk("requal_pulse_end", key_press, 5'h00);

    // Release everything together
    $display("step release all");
    key_in = 5'h1F;
    repeat (10) tick();
    chk("relall_release", key_release, 5'h15);
    chk("relall_level", key_level, 5'h00);
    chk("relall_toggle", key_toggle, 5'h15);
    tick();
    chk("relall_pulse_end", key_release, 5'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
